// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box overlay: pixel-loop states and box corners.
package bbox_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [1:0] {
        S_FETCH,
        S_CAPT,
        S_EMIT
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } box_t;

endpackage

// File: rtl/bbox_bounds.sv
// Converts one axis of a centre/size box into inclusive [lo, hi] pixel bounds,
// clamped to the start of the axis and to LIMIT-1 at the far end.
module bbox_bounds
    import bbox_pkg::*;
#(
    parameter int LIMIT = 640
) (
    input  logic [COORD_W-1:0] center,
    input  logic [COORD_W-1:0] size,
    output logic [COORD_W-1:0] lo,
    output logic [COORD_W-1:0] hi
);

    localparam logic [COORD_W-1:0] MAX_C = COORD_W'(LIMIT - 1);

    logic [COORD_W-1:0] half;
    logic [COORD_W:0]   end_w;

    always_comb begin
        half  = size >> 1;
        lo    = (center >= half) ? center - half : '0;
        // One extra bit so lo+size-1 past the frame edge clamps instead of wrapping.
        end_w = {1'b0, lo} + {1'b0, size} - (COORD_W + 1)'(1);
        hi    = (end_w > {1'b0, MAX_C}) ? MAX_C : end_w[COORD_W-1:0];
    end

endmodule

// File: rtl/bbox_overlay.sv
// Streams pixels FIFO-to-FIFO one at a time, painting a rectangular outline of the
// tracked box; the drawn box only changes at frame boundaries.
module bbox_overlay
    import bbox_pkg::*;
#(
    parameter int          WIDTH       = 640,
    parameter int          HEIGHT      = 480,
    parameter int          THICK       = 2,
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
    parameter int          HOLD_FRAMES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_empty,
    output logic               in_rd_en,
    input  logic [23:0]        in_dout,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic [23:0]        out_din,
    input  logic               box_valid,
    input  logic [COORD_W-1:0] center_x,
    input  logic [COORD_W-1:0] center_y,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic               box_active,
    output logic               frame_done
);

    localparam int                 AGE_W  = $clog2(HOLD_FRAMES + 1);
    localparam logic [AGE_W-1:0]   HOLD_C = AGE_W'(HOLD_FRAMES);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] TH     = COORD_W'(THICK);

    state_t             state, state_nxt;
    logic [COORD_W-1:0] x, y;
    box_t               act, pend, new_box;
    logic               pend_vld;
    logic [AGE_W-1:0]   age, age_inc;
    logic [COORD_W-1:0] nx0, nx1, ny0, ny1;
    logic               box_ok, last_px, in_x, in_y, on_border;

    bbox_bounds #(.LIMIT(WIDTH))  u_bnd_x (.center(center_x), .size(width),  .lo(nx0), .hi(nx1));
    bbox_bounds #(.LIMIT(HEIGHT)) u_bnd_y (.center(center_y), .size(height), .lo(ny0), .hi(ny1));

    always_comb begin
        new_box   = '{x0: nx0, y0: ny0, x1: nx1, y1: ny1};
        box_ok    = box_valid && (width != '0) && (height != '0);
        last_px   = (x == X_MAX) && (y == Y_MAX);
        in_x      = (x >= act.x0) && (x <= act.x1);
        in_y      = (y >= act.y0) && (y <= act.y1);
        // Differences are only meaningful inside the box, where they cannot underflow.
        on_border = box_active && in_x && in_y &&
                    (((x - act.x0) < TH) || ((act.x1 - x) < TH) ||
                     ((y - act.y0) < TH) || ((act.y1 - y) < TH));
        age_inc   = (age == HOLD_C) ? age : age + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        case (state)
            S_FETCH: if (!in_empty) begin
                in_rd_en  = reset;
                state_nxt = S_CAPT;
            end
            S_CAPT:  state_nxt = S_EMIT;
            S_EMIT:  if (!out_full) begin
                out_wr_en = reset;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        frame_done = out_wr_en && last_px;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_FETCH;
            x          <= '0;
            y          <= '0;
            act        <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            age        <= '0;
            box_active <= 1'b0;
            out_din    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAPT)
                out_din <= on_border ? BOX_COLOR : in_dout;
            if (out_wr_en) begin
                if (x == X_MAX) begin
                    x <= '0;
                    y <= (y == Y_MAX) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            if (frame_done) begin
                // A box arriving on the boundary cycle beats the pending one.
                if (box_ok || pend_vld) begin
                    act        <= box_ok ? new_box : pend;
                    pend_vld   <= 1'b0;
                    age        <= '0;
                    box_active <= 1'b1;
                end else begin
                    age <= age_inc;
                    if (age_inc == HOLD_C)
                        box_active <= 1'b0;
                end
            end else if (box_ok) begin
                pend     <= new_box;
                pend_vld <= 1'b1;
            end
        end
    end

endmodule
